two_parallel_serializer: RTL
============================

# two_parallel_serializer

Output stage placed directly downstream of the two-parallel FIR. It accepts one filtered pair per handshake (y(2k) on lane 0, y(2k+1) on lane 1, both full 64-bit signed), saturates each to OUT_W bits, buffers pairs in a small FIFO, and re-emits them as a single ready/valid sample stream in time order (lane 0 first). A sticky-free saturation counter reports how often clipping occurred.

## Interface
- OUT_W, 16: output sample width (signed), 2..32
- DEPTH, 4: FIFO depth in pairs, power of two, >= 2
- CNT_W, 16: saturation counter width
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_y0  in  64  signed, even-time output of filter (dout1)
- in_y1  in  64  signed, odd-time output of filter (dout2)
- in_valid  in  1  pair present
- in_ready  out  1  FIFO can accept a pair
- out_data  out  OUT_W  signed serial sample
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_sat  out  1  current out_data was clipped
- sat_count  out  CNT_W  number of clipped samples accepted into FIFO, saturates at all-ones
- level  out  clog2(DEPTH)+1  pairs currently stored

## Operation
- Push: in_valid && in_ready at an edge writes {sat(in_y0), sat(in_y1), flag0, flag1} at wr_ptr; wr_ptr increments mod DEPTH.
- Saturation: value > 2^(OUT_W-1)-1 -> 2^(OUT_W-1)-1, flag=1; value < -2^(OUT_W-1) -> -2^(OUT_W-1), flag=1; else low OUT_W bits, flag=0.
- sat_count += flag0 + flag1 on each push (0, 1 or 2); clamps at 2^CNT_W-1, never wraps.
- in_ready = (level != DEPTH) && !rst. Depends only on level, not on out_ready; a full FIFO refuses a push even in a cycle that pops.
- Output: head pair at rd_ptr; phase bit selects lane: phase=0 -> y0, phase=1 -> y1. out_sat is the matching flag.
- out_valid = (level != 0). out_data/out_sat are combinational from head and phase; held stable while out_valid && !out_ready.
- Handshake out_valid && out_ready: if phase=0, phase<-1; if phase=1, phase<-0, rd_ptr increments, pair popped.
- Simultaneous push and pop (non-full, non-empty): level unchanged, both pointers advance.
- Push into empty FIFO: no bypass; sample visible next cycle.
- Reset (any cycle, including mid-pair with phase=1): wr_ptr, rd_ptr, phase, level, sat_count <- 0; stored data discarded, FIFO contents not cleared.
- Output reset values: out_valid=0, in_ready=0 during rst then 1 in first cycle after, level=0, sat_count=0, out_data=don't-care but driven from array (tests must not check it while out_valid=0), out_sat=don't-care likewise.

## Timing
- Input-to-output latency: pair pushed at edge N -> out_valid=1 with y0 in cycle after N; with out_ready held 1, y0 accepted at edge N+1, y1 at edge N+2.
- Sustained throughput: 1 sample/clk out, so input average must be <= 1 pair per 2 clks; filter is expected to be pulse-fed accordingly.
- With out_ready=1 continuously and pairs every 2 cycles, level never exceeds 1.
- No combinational path from in_valid to out_valid; out_ready->in_ready path does not exist.
- Pointer wrap: DEPTH pushes return wr_ptr to 0; level distinguishes full from empty.

## Test plan
- Reset, out_ready=1, push (y0=100, y1=-200) once -> out_valid next cycle, out_data 100 then -200 on consecutive cycles, then out_valid=0, level back to 0.
- Push y0=40000, y1=-40000 (OUT_W=16) -> out_data 32767 (out_sat=1) then -32768 (out_sat=1); sat_count=2. Push y0=64'h7FFF_FFFF_FFFF_FFFF, y1=0 -> 32767, 0; sat_count=3.
- out_ready=0, push pairs 1..5 with in_valid held -> in_ready drops after 4 accepted (level=4), pair 5 held; release out_ready -> samples 1a,1b,…,4b in order, pair 5 accepted the cycle after level falls to 3.
- Full FIFO, out_ready=1 on sample 1b and in_valid=1 same cycle -> pop occurs, push refused that cycle, accepted next cycle; no sample lost or duplicated.
- Random in_valid/out_ready for 10k cycles against a scoreboard queue -> exact ordered match, pointer wraps exercised, sat_count equals reference clip count (clamped at 65535 test with CNT_W=4: stops at 15).
- Assert rst when phase=1 with 3 pairs stored -> next cycle out_valid=0, level=0, sat_count=0; fresh push emits its y0 first.

Source files
------------

// File: rtl/two_parallel_serializer.sv
// Output stage after the two-parallel FIR: saturates each filtered pair to OUT_W bits,
// buffers pairs in a small FIFO and re-emits them as one time-ordered sample stream.
module two_parallel_serializer #(
  parameter int OUT_W = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [63:0]        in_y0,
  input  logic signed [63:0]        in_y1,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sat,
  output logic [CNT_W-1:0]          sat_count,
  output logic [$clog2(DEPTH):0]    level
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a producer
  // holds its payload stable while valid && !ready, and ready never depends on valid.

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic signed [63:0] MAX_V = (64'sd1 <<< (OUT_W-1)) - 64'sd1;
  localparam logic signed [63:0] MIN_V = -(64'sd1 <<< (OUT_W-1));
  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  typedef enum logic {PH_Y0 = 1'b0, PH_Y1 = 1'b1} phase_t;

  // Returns {clip_flag, clipped_value}.
  function automatic logic [OUT_W:0] sat(input logic signed [63:0] v);
    if (v > MAX_V)      return {1'b1, MAX_V[OUT_W-1:0]};
    else if (v < MIN_V) return {1'b1, MIN_V[OUT_W-1:0]};
    else                return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0]   mem0 [DEPTH];
  logic [OUT_W:0]   mem1 [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  phase_t           phase_q, phase_d;
  logic [OUT_W:0]   sat0, sat1, head;
  logic             push, hs, pop;
  logic [AW:0]      level_d;
  logic [CNT_W+1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_d;

  assign in_ready  = (level != FULL) && !rst;
  assign out_valid = (level != '0);

  always_comb begin
    sat0     = sat(in_y0);
    sat1     = sat(in_y1);
    push     = in_valid && in_ready;
    hs       = out_valid && out_ready;
    pop      = hs && (phase_q == PH_Y1);
    phase_d  = phase_q;
    level_d  = level;
    head     = (phase_q == PH_Y0) ? mem0[rd_ptr] : mem1[rd_ptr];
    out_data = head[OUT_W-1:0];
    out_sat  = head[OUT_W];
    cnt_sum  = {2'b00, sat_count};
    cnt_d    = sat_count;
    if (hs) phase_d = (phase_q == PH_Y0) ? PH_Y1 : PH_Y0;
    if (push && !pop) level_d = level + (AW+1)'(1);
    if (pop && !push) level_d = level - (AW+1)'(1);
    if (push) begin
      cnt_sum = {2'b00, sat_count} + (CNT_W+2)'(sat0[OUT_W]) + (CNT_W+2)'(sat1[OUT_W]);
      // Clamp rather than wrap so the counter stays meaningful as a "lots of clipping" hint.
      cnt_d   = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      phase_q   <= PH_Y0;
      level     <= '0;
      sat_count <= '0;
    end else begin
      phase_q   <= phase_d;
      level     <= level_d;
      sat_count <= cnt_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage is never cleared; level alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem0[wr_ptr] <= sat0;
      mem1[wr_ptr] <= sat1;
    end
  end

endmodule
